// File: rtl/datapath_ctrl_pkg.sv
// Shared encodings for the datapath controller: instruction fields, select
// codes, FSM states and the packed control vector driven to the datapath.
package datapath_ctrl_pkg;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOVIMM  = 2'b10;
  localparam logic [1:0] OP_MOVREG  = 2'b00;

  localparam logic [2:0] NSEL_NONE  = 3'b000;
  localparam logic [2:0] NSEL_RN    = 3'b001;
  localparam logic [2:0] NSEL_RD    = 3'b010;
  localparam logic [2:0] NSEL_RM    = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b10;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_GET_A  = 3'd2,
    ST_GET_B  = 3'd3,
    ST_ALU    = 3'd4,
    ST_WR_RD  = 3'd5,
    ST_WR_IMM = 3'd6
  } state_t;

  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic       write;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
  } ctrl_t;

endpackage

// File: rtl/datapath_ctrl_if.sv
// Issue/control bundle between an instruction source and the controller.
// master issues instructions; slave is the controller driving the datapath.
interface datapath_ctrl_if #(parameter int IW = 16);

  logic          s;
  logic [IW-1:0] instr;
  logic          w;
  logic [2:0]    nsel;
  logic          write;
  logic [1:0]    vsel;
  logic          loada;
  logic          loadb;
  logic          loadc;
  logic          loads;
  logic          asel;
  logic          bsel;

  modport master (
    output s, instr,
    input  w, nsel, write, vsel, loada, loadb, loadc, loads, asel, bsel
  );

  modport slave (
    input  s, instr,
    output w, nsel, write, vsel, loada, loadb, loadc, loads, asel, bsel
  );

endinterface

// File: rtl/datapath_ctrl_decode.sv
// Combinational next-state and Moore output decode. Outputs depend on state
// and the captured opcode/op only; s affects next state in WAIT alone.
module datapath_ctrl_decode
  import datapath_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output ctrl_t      ctrl,
  output state_t     state_next
);

  logic is_mov;
  logic is_alu;

  assign is_mov = (opcode == OPC_MOV);
  assign is_alu = (opcode == OPC_ALU);

  always_comb begin
    ctrl       = '0;
    state_next = ST_WAIT;
    case (state)
      ST_WAIT: begin
        ctrl.w     = 1'b1;
        state_next = s ? ST_DECODE : ST_WAIT;
      end
      ST_DECODE: begin
        if (is_mov && op == OP_MOVIMM)      state_next = ST_WR_IMM;
        else if (is_mov && op == OP_MOVREG) state_next = ST_GET_B;
        else if (is_alu && op == OP_MVN)    state_next = ST_GET_B;
        else if (is_alu)                    state_next = ST_GET_A;
        else                                state_next = ST_WAIT;
      end
      ST_GET_A: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.loada = 1'b1;
        state_next = ST_GET_B;
      end
      ST_GET_B: begin
        ctrl.nsel  = NSEL_RM;
        ctrl.loadb = 1'b1;
        state_next = ST_ALU;
      end
      ST_ALU: begin
        // Single-operand ops pass B through by zeroing the A side.
        ctrl.asel  = is_mov || (is_alu && op == OP_MVN);
        ctrl.loads = 1'b1;
        if (is_alu && op == OP_CMP) begin
          state_next = ST_WAIT;
        end else begin
          ctrl.loadc = 1'b1;
          state_next = ST_WR_RD;
        end
      end
      ST_WR_RD: begin
        ctrl.nsel  = NSEL_RD;
        ctrl.vsel  = VSEL_C;
        ctrl.write = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WR_IMM: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.vsel  = VSEL_IMM;
        ctrl.write = 1'b1;
        state_next = ST_WAIT;
      end
      default: begin
        state_next = ST_WAIT;
      end
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle Moore controller top: holds the state and instruction registers
// and drives the datapath enables from the registered state.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  datapath_ctrl_if.slave  bus
);

  state_t        state_reg;
  state_t        state_next;
  logic [IW-1:0] ir_reg;
  ctrl_t         ctrl;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_WAIT;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_WAIT && bus.s) begin
        ir_reg <= bus.instr;
      end
    end
  end

  datapath_ctrl_decode u_decode (
    .state      (state_reg),
    .s          (bus.s),
    .opcode     (ir_reg[IW-1:IW-3]),
    .op         (ir_reg[IW-4:IW-5]),
    .ctrl       (ctrl),
    .state_next (state_next)
  );

  // Operand and immediate fields are consumed by the datapath, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir_reg[IW-6:0];

  assign bus.w     = ctrl.w;
  assign bus.nsel  = ctrl.nsel;
  assign bus.write = ctrl.write;
  assign bus.vsel  = ctrl.vsel;
  assign bus.loada = ctrl.loada;
  assign bus.loadb = ctrl.loadb;
  assign bus.loadc = ctrl.loadc;
  assign bus.loads = ctrl.loads;
  assign bus.asel  = ctrl.asel;
  assign bus.bsel  = ctrl.bsel;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: the driver queues the expected per-cycle
// control vector for each issued instruction; a monitor pops and compares.
module tb_datapath_ctrl;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  datapath_ctrl_if #(.IW(16)) bus ();

  datapath_ctrl #(.IW(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Vector layout: {w, nsel[2:0], write, vsel[1:0], loada, loadb, loadc, loads, asel, bsel}
  typedef struct {
    logic [12:0] v;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  localparam int K_IMM = 0;
  localparam int K_REG = 1;
  localparam int K_ADD = 2;
  localparam int K_CMP = 3;
  localparam int K_ILL = 4;

  localparam logic [12:0] E_WAIT   = 13'b1_000_0_00_0000_00;
  localparam logic [12:0] E_DEC    = 13'b0_000_0_00_0000_00;
  localparam logic [12:0] E_GETA   = 13'b0_001_0_00_1000_00;
  localparam logic [12:0] E_GETB   = 13'b0_100_0_00_0100_00;
  localparam logic [12:0] E_ALU2   = 13'b0_000_0_00_0011_00;
  localparam logic [12:0] E_ALU1   = 13'b0_000_0_00_0011_10;
  localparam logic [12:0] E_ALUCMP = 13'b0_000_0_00_0001_00;
  localparam logic [12:0] E_WRRD   = 13'b0_010_1_00_0000_00;
  localparam logic [12:0] E_WRIMM  = 13'b0_001_1_10_0000_00;

  function automatic logic [12:0] dut_vec();
    return {bus.w, bus.nsel, bus.write, bus.vsel, bus.loada, bus.loadb,
            bus.loadc, bus.loads, bus.asel, bus.bsel};
  endfunction

  task automatic push(input logic [12:0] v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic push_seq(input int kind, input string name);
    push(E_DEC, {name, ".decode"});
    case (kind)
      K_IMM: push(E_WRIMM, {name, ".wr_imm"});
      K_REG: begin
        push(E_GETB, {name, ".get_b"});
        push(E_ALU1, {name, ".alu"});
        push(E_WRRD, {name, ".wr_rd"});
      end
      K_ADD: begin
        push(E_GETA, {name, ".get_a"});
        push(E_GETB, {name, ".get_b"});
        push(E_ALU2, {name, ".alu"});
        push(E_WRRD, {name, ".wr_rd"});
      end
      K_CMP: begin
        push(E_GETA, {name, ".get_a"});
        push(E_GETB, {name, ".get_b"});
        push(E_ALUCMP, {name, ".alu"});
      end
      default: ;
    endcase
    push(E_WAIT, {name, ".done"});
  endtask

  // Monitor: one comparison per cycle against the queue head, plus the
  // mutual-exclusion rule on the enables every cycle.
  initial begin
    exp_t e;
    logic [12:0] got;
    forever begin
      @(posedge clock);
      #1;
      got = dut_vec();
      total++;
      if (int'(bus.loada) + int'(bus.loadb) + int'(bus.loadc) + int'(bus.write) > 1) begin
        bad++;
        $display("FAIL onehot_enables got=%b", got);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (got !== e.v) begin
          bad++;
          $display("FAIL %s got=%b exp=%b", e.tag, got, e.v);
        end
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while (q.size() > 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL %s_timeout left=%0d exp=0", name, q.size());
      q.delete();
    end
  endtask

  // Called on a negedge while idle in WAIT.
  task automatic issue(input logic [15:0] ins, input int kind, input string name,
                       input bit scramble);
    bus.instr = ins;
    bus.s     = 1'b1;
    push_seq(kind, name);
    @(negedge clock);
    bus.s = 1'b0;
    if (scramble) bus.instr = 16'hD305;
    @(negedge clock);
    if (scramble) bus.instr = 16'h0000;
    drain(name);
    $display("txn %s instr=%h kind=%0d queue_left=%0d", name, ins, kind, q.size());
  endtask

  typedef struct {
    logic [15:0] ins;
    int          kind;
    string       name;
    bit          scramble;
  } vec_t;

  vec_t vecs[] = '{
    '{16'hD305, K_IMM, "mov_imm",     1'b0},
    '{16'hA0A1, K_ADD, "add",         1'b0},
    '{16'hA901, K_CMP, "cmp",         1'b0},
    '{16'hB000, K_ADD, "and",         1'b0},
    '{16'hC000, K_REG, "mov_reg",     1'b0},
    '{16'hB800, K_REG, "mvn",         1'b0},
    '{16'h0000, K_ILL, "illegal_000", 1'b0},
    '{16'hC800, K_ILL, "illegal_mov01", 1'b0},
    '{16'hE000, K_ILL, "illegal_111", 1'b0},
    '{16'hA0A1, K_ADD, "add_scramble", 1'b1}
  };

  initial begin
    logic [12:0] got;
    reset_n   = 1'b0;
    bus.s     = 1'b0;
    bus.instr = 16'h0000;
    #1;
    got = dut_vec();
    total++;
    if (got !== E_WAIT) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", got, E_WAIT);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    foreach (vecs[i]) issue(vecs[i].ins, vecs[i].kind, vecs[i].name, vecs[i].scramble);

    // s held high: MOV imm then MVN captured on the intervening WAIT edge.
    bus.instr = 16'hD305;
    bus.s     = 1'b1;
    push_seq(K_IMM, "b2b_mov_imm");
    push_seq(K_REG, "b2b_mvn");
    @(negedge clock);
    bus.instr = 16'hB800;
    repeat (3) @(negedge clock);
    bus.s = 1'b0;
    drain("b2b");
    $display("txn b2b mov_imm+mvn queue_left=%0d", q.size());

    // Reset asserted mid-GET_B of an ADD.
    bus.instr = 16'hA0A1;
    bus.s     = 1'b1;
    push(E_DEC,  "rst_add.decode");
    push(E_GETA, "rst_add.get_a");
    push(E_GETB, "rst_add.get_b");
    @(negedge clock);
    bus.s = 1'b0;
    drain("rst_add");
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.w !== 1'b1 || bus.loadb !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort got_w=%b got_loadb=%b exp_w=1 exp_loadb=0",
               bus.w, bus.loadb);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) push(E_WAIT, "post_reset_idle");
    drain("post_reset");
    $display("txn reset_mid_add queue_left=%0d", q.size());

    // Idle after release must still accept a new instruction.
    issue(16'hD305, K_IMM, "mov_imm_after_reset", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
